// File: rtl/decoder_stream_pkg.sv
// Shared types and helpers for the streaming binary-to-one-hot decoder.
// Holds the occupancy state encoding, error-counter limits and the decode helper.
package decoder_stream_pkg;

   // Number of occupied storage entries in the skid buffer.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   localparam int ERR_CNT_W = 8;
   localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

   // One bit of the one-hot decode: bit idx is set when the code equals idx.
   // Called once per output bit from a generate loop, so it serves any code width.
   function automatic logic decode_onehot_bit(input logic [31:0] code, input int unsigned idx);
      return (code == 32'(idx));
   endfunction

endpackage

// File: rtl/decoder_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: a main register drives the output,
// a skid register catches the one beat that arrives while the consumer stalls.
module decoder_skid_buf
   import decoder_stream_pkg::*;
#(
   parameter int DW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data
);

   state_t          state_reg, state_next;
   logic [DW-1:0]   main_reg, main_next;
   logic [DW-1:0]   skid_reg, skid_next;
   logic            accept;
   logic            fire;

   // Both flags come straight from the state register, never from out_ready.
   assign in_ready  = (state_reg != TWO);
   assign out_valid = (state_reg != EMPTY);
   assign out_data  = main_reg;

   assign accept = in_valid && in_ready && !rst;
   assign fire   = out_valid && out_ready && !rst;

   always_comb begin
      state_next = state_reg;
      main_next  = main_reg;
      skid_next  = skid_reg;
      unique case (state_reg)
         EMPTY: begin
            if (accept) begin
               state_next = ONE;
               main_next  = in_data;
            end
         end
         ONE: begin
            if (accept && fire) begin
               main_next = in_data;
            end else if (accept) begin
               state_next = TWO;
               skid_next  = in_data;
            end else if (fire) begin
               state_next = EMPTY;
            end
         end
         TWO: begin
            // in_ready is low here, so only the drain path exists.
            if (fire) begin
               state_next = ONE;
               main_next  = skid_reg;
            end
         end
         default: begin
            state_next = EMPTY;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= EMPTY;
         main_reg  <= '0;
         skid_reg  <= '0;
      end else begin
         state_reg <= state_next;
         main_reg  <= main_next;
         skid_reg  <= skid_next;
      end
   end

endmodule

// File: rtl/decoder_stream.sv
// Streaming binary-to-one-hot decoder with registered, back-pressurable output.
// Unknown input codes become explicit all-zero error beats and are counted.
module decoder_stream
   import decoder_stream_pkg::*;
#(
   parameter int W = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [W-1:0]         in_code,
   input  logic                 in_unk,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [(2**W)-1:0]    out,
   output logic                 out_err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam int N = 2**W;

   logic [N-1:0]         in_onehot;
   logic [N:0]           in_payload;
   logic [N:0]           out_payload;
   logic                 accept;
   logic [ERR_CNT_W-1:0] err_cnt_reg, err_cnt_next;

   // An unknown code forces every select bit low regardless of in_code.
   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_dec
         assign in_onehot[gi] = !in_unk && decode_onehot_bit(32'(in_code), gi);
      end
   endgenerate

   assign in_payload = {in_unk, in_onehot};
   assign accept     = in_valid && in_ready && !rst;

   decoder_skid_buf #(
      .DW(N + 1)
   ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_payload),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_payload)
   );

   assign out     = out_payload[N-1:0];
   assign out_err = out_payload[N];

   // Counted at acceptance so the figure does not depend on consumer stalls.
   always_comb begin
      err_cnt_next = err_cnt_reg;
      if (accept && in_unk && (err_cnt_reg != ERR_CNT_MAX)) begin
         err_cnt_next = err_cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt_reg <= '0;
      end else begin
         err_cnt_reg <= err_cnt_next;
      end
   end

   assign err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_decoder_stream.sv
// Randomized scoreboard bench for decoder_stream at W=3: a driver pushes the
// expected one-hot/error beat on each accept, a monitor pops it on each fire.
module tb_decoder_stream;

   localparam int W = 3;
   localparam int N = 8;
   localparam int SEND_BOUND = 200;

   typedef struct {
      logic [N-1:0] oh;
      logic         err;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_code;
   logic         in_unk;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out;
   logic         out_err;
   logic [7:0]   err_cnt;

   exp_t q[$];
   int   model_cnt = 0;
   int   checks = 0;
   int   errors = 0;
   int   fire_cnt = 0;
   int   ready_mode = 1;
   bit   mon_en = 1'b0;

   always #5 clk = ~clk;

   decoder_stream #(.W(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_code  (in_code),
      .in_unk   (in_unk),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out      (out),
      .out_err  (out_err),
      .err_cnt  (err_cnt)
   );

   task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Consumer side: 0 = stalled, 1 = always ready, 2 = random ~70% ready.
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 9) < 7);
         endcase
      end
   end

   // Monitor: occupancy from the scoreboard predicts the flags; the head
   // entry must sit on OUT while valid and is retired on each fire.
   always @(negedge clk) begin
      if (mon_en) begin
         check(out_valid == (q.size() > 0), "out_valid", 64'(out_valid), 64'(q.size() > 0));
         check(in_ready == (q.size() < 2), "in_ready", 64'(in_ready), 64'(q.size() < 2));
         check(err_cnt == 8'(model_cnt), "err_cnt", 64'(err_cnt), 64'(model_cnt));
         if (out_valid && q.size() > 0) begin
            check(!$isunknown({out, out_err}), "no_x", 64'(out), 64'(q[0].oh));
            check(out == q[0].oh, "out", 64'(out), 64'(q[0].oh));
            check(out_err == q[0].err, "out_err", 64'(out_err), 64'(q[0].err));
            if (!q[0].err) begin
               check($onehot(out), "onehot", 64'(out), 64'(q[0].oh));
            end
            if (out_ready && !rst) begin
               $display("beat %0d out=%b err=%b err_cnt=%0d", fire_cnt, out, out_err, err_cnt);
               void'(q.pop_front());
               fire_cnt++;
            end
         end
      end
   end

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Holds a beat until accepted; expected result comes from 1 << code.
   task automatic send(input logic [W-1:0] code, input logic unk, output int waited);
      bit   done;
      exp_t e;
      done   = 1'b0;
      waited = 0;
      in_valid = 1'b1;
      in_code  = code;
      in_unk   = unk;
      while (!done) begin
         @(negedge clk);
         #1;
         if (in_ready && !rst) begin
            e.err = unk;
            e.oh  = unk ? '0 : (N'(1) << code);
            q.push_back(e);
            if (unk && model_cnt < 255) model_cnt++;
            done = 1'b1;
         end
         @(posedge clk);
         #1;
         if (!done) begin
            waited++;
            if (waited > SEND_BOUND) begin
               check(1'b0, "send_timeout", 64'(waited), 64'(SEND_BOUND));
               done = 1'b1;
            end
         end
      end
      in_valid = 1'b0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int w;
      int nb;
      int snap;
      rst = 1'b1;
      in_valid = 1'b0;
      in_code = '0;
      in_unk = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);
      check(out_valid == 1'b0, "rst_out_valid", 64'(out_valid), 64'd0);
      check(in_ready == 1'b1, "rst_in_ready", 64'(in_ready), 64'd1);
      check(out == '0, "rst_out", 64'(out), 64'd0);
      check(err_cnt == 8'd0, "rst_err_cnt", 64'(err_cnt), 64'd0);
      @(posedge clk);
      #1;

      // Streaming 0,1,0,1 at full rate.
      ready_mode = 1;
      idle(2);
      nb = 0;
      for (int i = 0; i < 4; i++) begin
         send(W'(i % 2), 1'b0, w);
         nb += w;
      end
      check(nb == 0, "stream_no_wait", 64'(nb), 64'd0);
      idle(3);

      // Single error beat, then saturation.
      send(W'(1), 1'b1, w);
      check(err_cnt == 8'd1, "err_first", 64'(err_cnt), 64'd1);
      @(negedge clk);
      check(out == '0 && out_err == 1'b1, "err_beat", 64'({out_err, out}), 64'h100);
      @(posedge clk);
      #1;
      for (int i = 0; i < 300; i++) send(W'($urandom_range(0, 7)), 1'b1, w);
      idle(3);
      check(err_cnt == 8'd255, "err_sat", 64'(err_cnt), 64'd255);

      // Stall with three beats pending, then release.
      ready_mode = 0;
      idle(2);
      fork
         begin
            send(W'(3), 1'b0, w);
            send(W'(4), 1'b0, w);
            send(W'(7), 1'b0, w);
         end
         begin
            repeat (5) @(posedge clk);
            @(negedge clk);
            check(in_ready == 1'b0 && out_valid == 1'b1, "stall_full", 64'({in_ready, out_valid}), 64'b01);
            ready_mode = 1;
         end
      join
      idle(4);

      // Reset while full and while a beat is offered.
      ready_mode = 0;
      idle(2);
      send(W'(2), 1'b0, w);
      send(W'(5), 1'b1, w);
      in_valid = 1'b1;
      in_code = W'(6);
      in_unk = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      #1;
      q.delete();
      model_cnt = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      in_valid = 1'b0;
      in_unk = 1'b0;
      @(negedge clk);
      check(out_valid == 1'b0, "mid_rst_out_valid", 64'(out_valid), 64'd0);
      check(out == '0, "mid_rst_out", 64'(out), 64'd0);
      check(err_cnt == 8'd0, "mid_rst_err_cnt", 64'(err_cnt), 64'd0);
      check(in_ready == 1'b1, "mid_rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      ready_mode = 1;
      idle(4);

      // Simultaneous accept and fire with alternating codes.
      snap = fire_cnt;
      nb = 0;
      for (int i = 0; i < 20; i++) begin
         send((i % 2) ? W'(5) : W'(2), 1'b0, w);
         nb += w;
      end
      idle(3);
      check(nb == 0, "no_bubble", 64'(nb), 64'd0);
      check(fire_cnt - snap == 20, "no_dup", 64'(fire_cnt - snap), 64'd20);

      // Random traffic on both sides.
      ready_mode = 2;
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 3) == 0) idle(1);
         send(W'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0), w);
      end
      ready_mode = 1;
      idle(6);
      check(q.size() == 0, "drain", 64'(q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
